// File: rtl/spi3w_target.sv
// 3-wire SPI mode-3 target with a 64 x 8 register file and a local preload port.
module spi3w_target #(
   parameter logic [7:0] DEVID = 8'hE5,
   parameter logic [5:0] RO_LO = 6'h30,
   parameter logic [5:0] RO_HI = 6'h39
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_sclk,
   input  logic       i_cs_n,
   inout  wire        io_sdio,
   input  logic       i_wr_en,
   input  logic [5:0] i_wr_addr,
   input  logic [7:0] i_wr_data,
   output logic       o_wr_stb,
   output logic [5:0] o_wr_addr,
   output logic [7:0] o_wr_data,
   output logic       o_busy,
   output logic       o_frame_err
);

   localparam int unsigned AW    = 6;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned CW    = 3;

   typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

   state_t          state, next_state;
   logic [1:0]      sclk_s, cs_s, sdio_s;
   logic            sclk_q, cs_q;
   logic [CW-1:0]   cnt;
   logic [DW-1:0]   shift, tx;
   logic [AW-1:0]   addr;
   logic            mb;
   logic            drv_en, sdo;
   logic [DW-1:0]   regs [DEPTH];
   logic            frame_err_c;

   wire             sclk_rise = sclk_s[1] & ~sclk_q;
   wire             sclk_fall = ~sclk_s[1] & sclk_q;
   wire             cs_rise   = cs_s[1] & ~cs_q;
   wire             cs_fall   = ~cs_s[1] & cs_q;
   wire [DW-1:0]    byte_c    = {shift[DW-2:0], sdio_s[1]};
   wire             last_bit  = (cnt == CW'(7));
   wire             ro_c      = (addr >= RO_LO) && (addr <= RO_HI);
   wire [AW-1:0]    addr_nx   = mb ? AW'(addr + AW'(1)) : addr;

   assign io_sdio = drv_en ? sdo : 1'bz;

   // Two-flop synchronizers plus one delay stage for edge detection; left
   // unreset so they always track the pins and a reset cannot fake an edge.
   always_ff @(posedge i_clk) begin
      sclk_s <= {sclk_s[0], i_sclk};
      cs_s   <= {cs_s[0], i_cs_n};
      sdio_s <= {sdio_s[0], io_sdio};
      sclk_q <= sclk_s[1];
      cs_q   <= cs_s[1];
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state decode; chip-select release overrides everything.
   always_comb begin
      next_state  = state;
      frame_err_c = 1'b0;
      if (cs_rise) begin
         next_state  = IDLE;
         frame_err_c = (state != IDLE) && (cnt != '0);
      end else begin
         case (state)
            IDLE:    if (cs_fall) next_state = CMD;
            CMD:     if (sclk_rise && last_bit) next_state = byte_c[7] ? RD : WR;
            default: next_state = state;
         endcase
      end
   end

   // Shift/count datapath, register file, read driver and status outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt         <= '0;
         shift       <= '0;
         tx          <= '0;
         addr        <= '0;
         mb          <= 1'b0;
         drv_en      <= 1'b0;
         sdo         <= 1'b0;
         o_wr_stb    <= 1'b0;
         o_wr_addr   <= '0;
         o_wr_data   <= '0;
         o_busy      <= 1'b0;
         o_frame_err <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
         regs[0] <= DEVID;
      end else begin
         o_wr_stb    <= 1'b0;
         o_frame_err <= frame_err_c;
         o_busy      <= ~cs_s[1];
         // Local write first so a writable SPI commit to the same address wins.
         if (i_wr_en) regs[i_wr_addr] <= i_wr_data;
         if (cs_rise) begin
            cnt    <= '0;
            drv_en <= 1'b0;
         end else begin
            case (state)
               IDLE: if (cs_fall) cnt <= '0;
               CMD: if (sclk_rise) begin
                  shift <= byte_c;
                  cnt   <= CW'(cnt + CW'(1));
                  if (last_bit) begin
                     mb   <= byte_c[6];
                     addr <= byte_c[AW-1:0];
                     tx   <= regs[byte_c[AW-1:0]];
                  end
               end
               WR: if (sclk_rise) begin
                  shift <= byte_c;
                  cnt   <= CW'(cnt + CW'(1));
                  if (last_bit) begin
                     o_wr_stb  <= 1'b1;
                     o_wr_addr <= addr;
                     o_wr_data <= byte_c;
                     if (!ro_c) regs[addr] <= byte_c;
                     addr <= addr_nx;
                  end
               end
               RD: begin
                  if (sclk_fall) begin
                     drv_en <= 1'b1;
                     sdo    <= tx[DW-1];
                     tx     <= {tx[DW-2:0], 1'b0};
                  end
                  if (sclk_rise) begin
                     cnt <= CW'(cnt + CW'(1));
                     if (last_bit) begin
                        addr <= addr_nx;
                        tx   <= regs[addr_nx];
                     end
                  end
               end
               default: cnt <= cnt;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi3w_target.sv
// Directed bench for spi3w_target: bench-side SPI controller, register-file
// model, and a per-cycle monitor for write strobes, frame errors and release.
module tb_spi3w_target;

   logic       clk = 1'b0;
   logic       rst, sclk, cs_n, wr_en;
   logic [5:0] wr_addr;
   logic [7:0] wr_data;
   logic       m_en, m_out;
   wire        io_sdio;
   wire        wr_stb, busy, ferr;
   wire  [5:0] o_wa;
   wire  [7:0] o_wd;

   assign io_sdio = m_en ? m_out : 1'bz;
   pullup (io_sdio);

   spi3w_target dut (
      .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_cs_n(cs_n), .io_sdio(io_sdio),
      .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .o_wr_stb(wr_stb), .o_wr_addr(o_wa), .o_wr_data(o_wd),
      .o_busy(busy), .o_frame_err(ferr)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [5:0] a; logic [7:0] d;} wr_t;

   int         checks = 0;
   int         fails  = 0;
   int         errs_seen = 0;
   bit         exp_rel = 1'b0;
   logic [7:0] mregs [64];
   wr_t        exp_q [$];
   logic [7:0] rxq [$];
   wr_t        mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_ro(input logic [5:0] a);
      return (a >= 6'h30) && (a <= 6'h39);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) mregs[i] = 8'h00;
      mregs[0] = 8'hE5;
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: sampled 2 ns after the active edge.
   always begin
      @(posedge clk);
      #2;
      if (!rst) begin
         if (wr_stb) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_wr_stb", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("wr_stb_addr", 32'(o_wa), 32'(mon_e.a));
               chk("wr_stb_data", 32'(o_wd), 32'(mon_e.d));
            end
         end
         if (ferr) errs_seen++;
         if (exp_rel && !m_en) chk("sdio_released", 32'(io_sdio), 32'd1);
      end
   end

   // One SCLK bit per iteration: 8 clk low, 8 clk high; optional local write
   // lined up with the commit of the final bit.
   task automatic xfer(input logic [7:0] txb, input int nbits, input bit drive,
                       output logic [7:0] rx, input bit coll, input logic [5:0] ca,
                       input logic [7:0] cd);
      rx = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         sclk  = 1'b0;
         m_en  = drive;
         m_out = drive ? txb[i] : 1'b0;
         wait_clk(8);
         rx[i] = io_sdio;
         sclk  = 1'b1;
         if (coll && i == 0) begin
            wait_clk(2);
            wr_en = 1'b1; wr_addr = ca; wr_data = cd;
            wait_clk(1);
            wr_en = 1'b0;
            wait_clk(5);
         end else begin
            wait_clk(8);
         end
      end
   endtask

   task automatic cs_begin();
      cs_n = 1'b0;
      wait_clk(8);
      chk("busy_in_frame", 32'(busy), 32'd1);
   endtask

   task automatic cs_end();
      m_en = 1'b0;
      cs_n = 1'b1;
      wait_clk(8);
      exp_rel = 1'b1;
      chk("busy_after_frame", 32'(busy), 32'd0);
   endtask

   task automatic lw(input logic [5:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      wait_clk(1);
      wr_en = 1'b0;
      mregs[a] = d;
   endtask

   task automatic spi_write(input logic [5:0] a, input logic [7:0] d, input bit coll,
                            input logic [7:0] cd);
      logic [7:0] rx;
      wr_t e;
      cs_begin();
      xfer({2'b00, a}, 8, 1'b1, rx, 1'b0, 6'h0, 8'h0);
      e.a = a; e.d = d;
      exp_q.push_back(e);
      if (coll) mregs[a] = cd;
      if (!is_ro(a)) mregs[a] = d;
      xfer(d, 8, 1'b1, rx, coll, a, cd);
      cs_end();
   endtask

   task automatic spi_read(input logic [5:0] a, input bit mb, input int n);
      logic [7:0] rx;
      logic [5:0] p;
      p = a;
      rxq.delete();
      cs_begin();
      xfer({1'b1, mb, a}, 8, 1'b1, rx, 1'b0, 6'h0, 8'h0);
      exp_rel = 1'b0;
      for (int k = 0; k < n; k++) begin
         xfer(8'h00, 8, 1'b0, rx, 1'b0, 6'h0, 8'h0);
         chk("rd_byte_model", 32'(rx), 32'(mregs[p]));
         rxq.push_back(rx);
         if (mb) p = 6'(p + 6'd1);
      end
      cs_end();
   endtask

   initial begin
      logic [7:0] rx;
      int         e0;
      rst = 1'b1; sclk = 1'b1; cs_n = 1'b1; m_en = 1'b0; m_out = 1'b0;
      wr_en = 1'b0; wr_addr = 6'h0; wr_data = 8'h0;
      model_reset();
      wait_clk(5);
      chk("rst_wr_stb", 32'(wr_stb), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_err", 32'(ferr), 32'd0);
      rst = 1'b0;
      wait_clk(5);
      exp_rel = 1'b1;
      chk("idle_released", 32'(io_sdio), 32'd1);

      // Device ID
      spi_read(6'h00, 1'b0, 1);
      chk("devid_lit", 32'(rxq[0]), 32'hE5);

      // Write then read back, then repeated byte without auto-increment
      spi_write(6'h2D, 8'h08, 1'b0, 8'h00);
      spi_read(6'h2D, 1'b0, 1);
      chk("readback_lit", 32'(rxq[0]), 32'h08);
      spi_read(6'h2D, 1'b0, 2);
      chk("mb0_repeat_lit", 32'(rxq[1]), 32'h08);

      // Burst read of preloaded axis registers
      for (int k = 0; k < 6; k++) lw(6'(6'h32 + k), 8'(k + 1));
      spi_read(6'h32, 1'b1, 6);
      for (int k = 0; k < 6; k++) chk("burst_lit", 32'(rxq[k]), 32'(k + 1));

      // Address wrap 0x3F -> 0x00
      lw(6'h3F, 8'hC3);
      spi_read(6'h3F, 1'b1, 2);
      chk("wrap_3f_lit", 32'(rxq[0]), 32'hC3);
      chk("wrap_00_lit", 32'(rxq[1]), 32'hE5);

      // Read-only address: strobe still pulses, register unchanged
      spi_write(6'h32, 8'hAA, 1'b0, 8'h00);
      spi_read(6'h32, 1'b0, 1);
      chk("ro_unchanged_lit", 32'(rxq[0]), 32'h01);

      // Same-cycle collisions
      spi_write(6'h2C, 8'h11, 1'b1, 8'h22);
      spi_read(6'h2C, 1'b0, 1);
      chk("coll_rw_lit", 32'(rxq[0]), 32'h11);
      spi_write(6'h33, 8'h44, 1'b1, 8'h55);
      spi_read(6'h33, 1'b0, 1);
      chk("coll_ro_lit", 32'(rxq[0]), 32'h55);

      // Abort after 5 data bits of a write
      lw(6'h20, 8'h5A);
      e0 = errs_seen;
      cs_begin();
      xfer(8'h20, 8, 1'b1, rx, 1'b0, 6'h0, 8'h0);
      xfer(8'hFF, 5, 1'b1, rx, 1'b0, 6'h0, 8'h0);
      cs_end();
      chk("abort_frame_err", 32'(errs_seen), 32'(e0 + 1));
      spi_read(6'h20, 1'b0, 1);
      chk("abort_reg_lit", 32'(rxq[0]), 32'h5A);

      // Reset in the middle of a read of 0x2D (0x08: top bits are 0)
      cs_begin();
      xfer(8'hAD, 8, 1'b1, rx, 1'b0, 6'h0, 8'h0);
      exp_rel = 1'b0;
      xfer(8'h00, 3, 1'b0, rx, 1'b0, 6'h0, 8'h0);
      sclk = 1'b0; m_en = 1'b0;
      wait_clk(6);
      chk("rd_bit_driven", 32'(io_sdio), 32'd0);
      rst = 1'b1;
      wait_clk(1);
      chk("rst_midframe_release", 32'(io_sdio), 32'd1);
      rst = 1'b0;
      model_reset();
      wait_clk(2);
      sclk = 1'b1;
      wait_clk(8);
      xfer(8'h00, 4, 1'b0, rx, 1'b0, 6'h0, 8'h0);
      e0 = errs_seen;
      cs_end();
      chk("rst_no_frame_err", 32'(errs_seen), 32'(e0));
      spi_read(6'h00, 1'b0, 1);
      chk("post_rst_devid_lit", 32'(rxq[0]), 32'hE5);
      spi_read(6'h2D, 1'b0, 1);
      chk("post_rst_reg_lit", 32'(rxq[0]), 32'h00);

      wait_clk(4);
      chk("pending_wr_stb", 32'(exp_q.size()), 32'd0);
      chk("total_frame_errs", 32'(errs_seen), 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
